maxpool_relu_2x2: RTL and testbench

Streaming 2×2/stride-2 max-pool with optional ReLU, placed directly downstream of `systolic_wrapper`/result handler in the LeNet pipeline. It consumes convolution outputs one pixel per beat in raster order, with all output channels in parallel, and produces the pooled feature map in raster order. For LeNet layer 1 it turns the 24×24×6 conv map into 12×12×6. A one-row line buffer holds partial maxima, so no full frame is ever stored.

---
 rtl/maxpool_relu_2x2_if.sv | 25 ++
 rtl/maxpool_relu_2x2.sv | 200 ++++++++++++++++++++
 tb/tb_maxpool_relu_2x2.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_relu_2x2_if.sv
// rtl/maxpool_relu_2x2_if.sv - pixel-in / pooled-out stream bundle for maxpool_relu_2x2
interface maxpool_relu_2x2_if #(
   parameter int NUM_CH = 6,
   parameter int DATA_W = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [NUM_CH*DATA_W-1:0] out_data;
   logic                     out_last;

   // producer of pixels and consumer of pooled pixels
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   // the pooling block itself
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/maxpool_relu_2x2.sv
// rtl/maxpool_relu_2x2.sv - streaming 2x2/stride-2 signed max-pool with optional ReLU
module maxpool_relu_2x2 #(
   parameter int NUM_CH   = 6,
   parameter int DATA_W   = 32,
   parameter int MAX_IN_W = 32,
   parameter int DIM_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_async_n_i,
   input  logic [DIM_W-1:0] cfg_in_w_i,
   input  logic [DIM_W-1:0] cfg_in_h_i,
   input  logic             cfg_relu_en_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   maxpool_relu_2x2_if.slave strm_if
);
   localparam int DW       = NUM_CH * DATA_W;
   localparam int LB_DEPTH = MAX_IN_W / 2;
   localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [DIM_W-1:0] cfg_w_q, cfg_w_d;
   logic [DIM_W-1:0] cfg_h_q, cfg_h_d;
   logic             relu_q, relu_d;
   logic [DIM_W-1:0] col_q, col_d;
   logic [DIM_W-1:0] row_q, row_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [DW-1:0]    hmax_q, hmax_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [DW-1:0]    linebuf_q [LB_DEPTH];

   logic             in_ready;
   logic             fire;
   logic             col_last;
   logic             row_last;
   logic             win_last;
   logic             load;
   logic             lb_we;
   logic [LB_AW-1:0] lb_idx;
   logic [DW-1:0]    lb_rd;
   logic [DW-1:0]    pm_flat;
   logic [DW-1:0]    res_flat;
   logic [DIM_W-2:0] wo_m1;
   logic [DIM_W-2:0] ho_m1;

   function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   function automatic logic [DATA_W-1:0] relu(input logic en, input logic [DATA_W-1:0] v);
      return (en && v[DATA_W-1]) ? '0 : v;
   endfunction

   // Every beat stalls while a pooled pixel is waiting on downstream, odd or even column alike.
   assign in_ready = (state_q == S_RUN) && !(out_valid_q && !strm_if.out_ready);
   assign fire     = in_ready && strm_if.in_valid;
   assign col_last = (col_q == cfg_w_q - DIM_W'(1));
   assign row_last = (row_q == cfg_h_q - DIM_W'(1));
   assign wo_m1    = cfg_w_q[DIM_W-1:1] - (DIM_W-1)'(1);
   assign ho_m1    = cfg_h_q[DIM_W-1:1] - (DIM_W-1)'(1);
   assign win_last = (col_q[DIM_W-1:1] == wo_m1) && (row_q[DIM_W-1:1] == ho_m1);
   assign lb_idx   = col_q[LB_AW:1];
   assign lb_rd    = linebuf_q[lb_idx];
   assign lb_we    = fire && col_q[0] && !row_q[0];
   assign load     = fire && col_q[0] && row_q[0];

   // Per-channel horizontal pair max, then vertical max against the stored top-row pair.
   always_comb begin
      pm_flat  = '0;
      res_flat = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         pm_flat[c*DATA_W +: DATA_W]  = smax(hmax_q[c*DATA_W +: DATA_W],
                                             strm_if.in_data[c*DATA_W +: DATA_W]);
         res_flat[c*DATA_W +: DATA_W] = relu(relu_q, smax(lb_rd[c*DATA_W +: DATA_W],
                                                          pm_flat[c*DATA_W +: DATA_W]));
      end
   end

   // Control FSM next state, config capture and raster counters.
   always_comb begin
      state_d = state_q;
      cfg_w_d = cfg_w_q;
      cfg_h_d = cfg_h_q;
      relu_d  = relu_q;
      col_d   = col_q;
      row_d   = row_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cfg_w_d = cfg_in_w_i;
               cfg_h_d = cfg_in_h_i;
               relu_d  = cfg_relu_en_i;
               col_d   = '0;
               row_d   = '0;
               busy_d  = 1'b1;
               // An empty frame has no beats to wait for.
               state_d = ((cfg_in_w_i == '0) || (cfg_in_h_i == '0)) ? S_FLUSH : S_RUN;
            end
         end
         S_RUN: begin
            if (fire) begin
               if (col_last) begin
                  col_d = '0;
                  if (row_last) begin
                     row_d   = '0;
                     state_d = S_FLUSH;
                  end else begin
                     row_d = row_q + DIM_W'(1);
                  end
               end else begin
                  col_d = col_q + DIM_W'(1);
               end
            end
         end
         S_FLUSH: begin
            if (!out_valid_q) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Left-pixel capture and the single-entry output register with same-cycle reload.
   always_comb begin
      hmax_d      = hmax_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (fire && !col_q[0]) hmax_d = strm_if.in_data;
      if (out_valid_q && strm_if.out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = res_flat;
         out_last_d  = win_last;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   // Config, counters, status and datapath registers.
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         cfg_w_q     <= '0;
         cfg_h_q     <= '0;
         relu_q      <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         hmax_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         cfg_w_q     <= cfg_w_d;
         cfg_h_q     <= cfg_h_d;
         relu_q      <= relu_d;
         col_q       <= col_d;
         row_q       <= row_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         hmax_q      <= hmax_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // Line buffer of top-row pair maxima; every entry is written before it is read in a frame.
   always_ff @(posedge clk_i) begin
      if (lb_we) linebuf_q[lb_idx] <= pm_flat;
   end

   assign strm_if.in_ready  = in_ready;
   assign strm_if.out_valid = out_valid_q;
   assign strm_if.out_data  = out_data_q;
   assign strm_if.out_last  = out_last_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
endmodule

// File: tb/tb_maxpool_relu_2x2.sv
// tb/tb_maxpool_relu_2x2.sv - scoreboard bench for maxpool_relu_2x2
module tb_maxpool_relu_2x2;
   localparam int NUM_CH   = 6;
   localparam int DATA_W   = 16;
   localparam int MAX_IN_W = 32;
   localparam int DIM_W    = 8;
   localparam int DW       = NUM_CH * DATA_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [DIM_W-1:0] cfg_w = '0;
   logic [DIM_W-1:0] cfg_h = '0;
   logic             cfg_relu = 1'b0;
   logic             start = 1'b0;
   logic             busy;
   logic             done;

   int               tests = 0;
   int               errors = 0;
   int               out_cnt = 0;
   int               done_cnt = 0;
   bit               stall_en = 1'b0;
   bit               cur_relu = 1'b0;
   bit               aborted = 1'b0;
   logic [DW:0]      exp_q [$];
   logic [DW:0]      e;
   logic             neg;
   logic [DW-1:0]    frame [0:1023];

   maxpool_relu_2x2_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) m_if ();

   maxpool_relu_2x2 #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_IN_W(MAX_IN_W), .DIM_W(DIM_W)
   ) dut (
      .clk_i        (clk),
      .rst_async_n_i(rst_n),
      .cfg_in_w_i   (cfg_w),
      .cfg_in_h_i   (cfg_h),
      .cfg_relu_en_i(cfg_relu),
      .start_i      (start),
      .busy_o       (busy),
      .done_o       (done),
      .strm_if      (m_if.slave)
   );

   always #5 clk = ~clk;

   // downstream ready: always high, or a fair coin per cycle while stalling
   initial begin
      m_if.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // scoreboard pop on every output handshake, plus the backpressure rule
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_if.out_valid && m_if.out_ready) begin
            out_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_extra: got data=%h last=%b, required no output", m_if.out_data, m_if.out_last);
            end else begin
               e = exp_q.pop_front();
               if ({m_if.out_data, m_if.out_last} !== e) begin
                  errors++;
                  $display("FAIL scoreboard_beat %0d: got data=%h last=%b, required data=%h last=%b",
                           out_cnt - 1, m_if.out_data, m_if.out_last, e[DW:1], e[0]);
               end
            end
            if (cur_relu) begin
               neg = 1'b0;
               for (int c = 0; c < NUM_CH; c++) if (m_if.out_data[c*DATA_W + DATA_W - 1]) neg = 1'b1;
               tests++;
               if (neg !== 1'b0) begin
                  errors++;
                  $display("FAIL relu_negative: got data=%h, required no negative channel", m_if.out_data);
               end
            end
         end
         if (m_if.out_valid && !m_if.out_ready) begin
            tests++;
            if (m_if.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL backpressure_in_ready: got %b, required 0", m_if.in_ready);
            end
         end
         if (done) done_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] pack_all(input int v);
      logic [DW-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(v);
      return r;
   endfunction

   function automatic logic [DW-1:0] ch0(input int v);
      logic [DW-1:0] r;
      r = '0;
      r[DATA_W-1:0] = DATA_W'(v);
      return r;
   endfunction

   function automatic int sx(input logic [DW-1:0] v, input int c);
      logic signed [DATA_W-1:0] t;
      t = v[c*DATA_W +: DATA_W];
      return int'(t);
   endfunction

   task automatic send_beat(input logic [DW-1:0] d);
      int guard;
      guard = 0;
      m_if.in_valid = 1'b1;
      m_if.in_data  = d;
      @(negedge clk);
      while (m_if.in_ready !== 1'b1 && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      if (m_if.in_ready !== 1'b1) begin
         tests++;
         errors++;
         aborted = 1'b1;
         $display("FAIL beat_accept_timeout: in_ready=%b, required 1", m_if.in_ready);
      end
      @(posedge clk);
      #1;
      m_if.in_valid = 1'b0;
   endtask

   task automatic run_frame(input int w, input int h, input bit relu_en, input bit stall, input bit use_model);
      int d0, o0, nexp, guard, m;
      logic [DW-1:0] d;
      if (use_model) begin
         for (int i = 0; i < h / 2; i++) begin
            for (int j = 0; j < w / 2; j++) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  m = sx(frame[(2*i)*w + 2*j], c);
                  if (sx(frame[(2*i)*w + 2*j + 1], c) > m) m = sx(frame[(2*i)*w + 2*j + 1], c);
                  if (sx(frame[(2*i+1)*w + 2*j], c) > m) m = sx(frame[(2*i+1)*w + 2*j], c);
                  if (sx(frame[(2*i+1)*w + 2*j + 1], c) > m) m = sx(frame[(2*i+1)*w + 2*j + 1], c);
                  if (relu_en && m < 0) m = 0;
                  d[c*DATA_W +: DATA_W] = DATA_W'(m);
               end
               exp_q.push_back({d, (i == h/2 - 1) && (j == w/2 - 1)});
            end
         end
      end
      nexp = exp_q.size();
      d0 = done_cnt;
      o0 = out_cnt;
      cfg_w = DIM_W'(w);
      cfg_h = DIM_W'(h);
      cfg_relu = relu_en;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cfg_w = '0;
      cfg_h = '0;
      cfg_relu = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise %0dx%0d: got %b, required 1", w, h, busy);
      end
      stall_en = stall;
      cur_relu = relu_en;
      for (int k = 0; k < w * h; k++) begin
         if (aborted) break;
         send_beat(frame[k]);
      end
      guard = 0;
      while (done !== 1'b1 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      tests++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout %0dx%0d: got done=%b, required 1", w, h, done);
      end
      tests++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_fall %0dx%0d: got %b with done, required 0", w, h, busy);
      end
      @(negedge clk);
      tests++;
      if (done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL done_pulses %0dx%0d: got %0d, required 1", w, h, done_cnt - d0);
      end
      tests++;
      if (out_cnt - o0 != nexp) begin
         errors++;
         $display("FAIL output_count %0dx%0d: got %0d, required %0d", w, h, out_cnt - o0, nexp);
      end
      tests++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left %0dx%0d: got %0d pending, required 0", w, h, exp_q.size());
      end
      exp_q.delete();
      stall_en = 1'b0;
      cur_relu = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      tests++;
      if ({busy, done, m_if.in_ready, m_if.out_valid, m_if.out_last} !== 5'b0) begin
         errors++;
         $display("FAIL %s_flags: got busy=%b done=%b in_ready=%b out_valid=%b out_last=%b, required all 0",
                  tag, busy, done, m_if.in_ready, m_if.out_valid, m_if.out_last);
      end
      tests++;
      if (m_if.out_data !== '0) begin
         errors++;
         $display("FAIL %s_out_data: got %h, required 0", tag, m_if.out_data);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_if.in_valid = 1'b1;
      #1;
      tests++;
      if (m_if.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_in_ready: got %b, required 0", m_if.in_ready);
      end
      m_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_4x4();
      for (int k = 0; k < 16; k++) frame[k] = ch0(k);
      exp_q.push_back({ch0(5), 1'b0});
      exp_q.push_back({ch0(7), 1'b0});
      exp_q.push_back({ch0(13), 1'b0});
      exp_q.push_back({ch0(15), 1'b1});
      run_frame(4, 4, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_odd_5x3();
      for (int k = 0; k < 15; k++) frame[k] = pack_all(-1);
      frame[0] = pack_all(-8);
      frame[6] = pack_all(3);
      exp_q.push_back({pack_all(3), 1'b0});
      exp_q.push_back({pack_all(-1), 1'b1});
      run_frame(5, 3, 1'b0, 1'b0, 1'b0);
      exp_q.push_back({pack_all(3), 1'b0});
      exp_q.push_back({pack_all(0), 1'b1});
      run_frame(5, 3, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_lenet_random();
      for (int k = 0; k < 576; k++)
         for (int c = 0; c < NUM_CH; c++) frame[k][c*DATA_W +: DATA_W] = DATA_W'($urandom);
      run_frame(24, 24, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_frame(24, 24, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_restart_and_reset();
      for (int k = 0; k < 16; k++) frame[k] = ch0(k);
      exp_q.push_back({ch0(5), 1'b0});
      exp_q.push_back({ch0(7), 1'b0});
      cfg_w = DIM_W'(4);
      cfg_h = DIM_W'(4);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 6; k++) send_beat(frame[k]);
      cfg_w = DIM_W'(2);
      cfg_h = DIM_W'(2);
      cfg_relu = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_busy: got %b, required 1", busy);
      end
      for (int k = 6; k < 14; k++) send_beat(frame[k]);
      tests++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL restart_ignored: got %0d pending outputs, required 0", exp_q.size());
      end
      tests++;
      if ({m_if.out_valid, m_if.out_data} !== {1'b1, ch0(13)}) begin
         errors++;
         $display("FAIL restart_window13: got valid=%b data=%h, required valid=1 data=%h",
                  m_if.out_valid, m_if.out_data, ch0(13));
      end
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midframe_reset");
      cfg_w = '0;
      cfg_h = '0;
      cfg_relu = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_if.in_valid = 1'b1;
      m_if.in_data = ch0(99);
      #1;
      tests++;
      if ({m_if.in_ready, busy} !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_idle: got in_ready=%b busy=%b, required 0 0", m_if.in_ready, busy);
      end
      m_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      test_basic_4x4();
   endtask

   task automatic test_narrow_1x8();
      for (int k = 0; k < 8; k++) frame[k] = pack_all(k + 1);
      run_frame(1, 8, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      m_if.in_valid = 1'b0;
      m_if.in_data  = '0;
      test_reset();
      test_basic_4x4();
      test_odd_5x3();
      test_lenet_random();
      test_back_to_back();
      test_restart_and_reset();
      test_narrow_1x8();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
